// File: rtl/key_cmd_if.sv
// key_cmd_if: valid/ready command channel carrying one key code per transfer.
interface key_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_code;
    logic       cmd_repeat;
    modport master (output cmd_valid, cmd_code, cmd_repeat, input cmd_ready);
    modport slave (input cmd_valid, cmd_code, cmd_repeat, output cmd_ready);
endinterface

// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler: serializes key presses by fixed priority, adds typematic repeat
// for movement keys, and queues the resulting commands in a small FIFO.
module key_cmd_scheduler #(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [9:0]                   keys,
    input  logic                         clear_dropped,
    key_cmd_if.master                    cmd,
    output logic                         dropped,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     trk, trk_n;
    logic           rep_pend, rep_pend_n, rep_drop;
    logic [9:0]     key_q, pending, pending_n, rise;
    logic [3:0]     sel;
    logic [4:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           has_pend, pop, push, key_push, rep_push, retrack;
    always_comb begin
        rise = keys & ~key_q;
        has_pend = |pending;
        sel = '0;
        for (int i = 9; i >= 0; i--)
            if (pending[i]) sel = 4'(i);
        pop = cmd.cmd_valid & cmd.cmd_ready;
        push = (fifo_level != (AW+1)'(FIFO_DEPTH) || pop) && (has_pend || rep_pend);
        key_push = push & has_pend;
        rep_push = push & ~has_pend;
        retrack = key_push & ~sel[3];
        pending_n = (pending & ~(10'(key_push) << sel)) | rise;
    end
    // a new movement press retracks before release or expiry is considered
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        trk_n = trk;
        rep_pend_n = rep_pend & ~rep_push;
        rep_drop = 1'b0;
        if (retrack) begin
            state_n = DELAY;
            trk_n = sel[2:0];
            cnt_n = CW'(REPEAT_DELAY - 1);
            rep_pend_n = 1'b0;
        end else if (state != IDLE && !keys[trk]) begin
            state_n = IDLE;
            rep_pend_n = 1'b0;
        end else if (state != IDLE && cnt == '0) begin
            state_n = REPEAT;
            cnt_n = CW'(REPEAT_RATE - 1);
            rep_pend_n = 1'b1;
            rep_drop = rep_pend & ~rep_push;
        end else if (state != IDLE) begin
            cnt_n = cnt - 1'b1;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_q <= '1;
            pending <= '0;
            state <= IDLE;
            cnt <= '0;
            trk <= '0;
            rep_pend <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_level <= '0;
            dropped <= 1'b0;
        end else begin
            key_q <= keys;
            pending <= pending_n;
            state <= state_n;
            cnt <= cnt_n;
            trk <= trk_n;
            rep_pend <= rep_pend_n;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            dropped <= (|(rise & pending)) | rep_drop | (dropped & ~clear_dropped);
        end
    end
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= {~has_pend, has_pend ? sel : {1'b0, trk}};
    assign cmd.cmd_valid = |fifo_level;
    assign cmd.cmd_code = cmd.cmd_valid ? mem[rd_ptr][3:0] : '0;
    assign cmd.cmd_repeat = cmd.cmd_valid & mem[rd_ptr][4];
endmodule

// File: tb/tb_key_cmd_scheduler.sv
// tb_key_cmd_scheduler: directed stimulus checked every cycle against a time-based reference model.
module tb_key_cmd_scheduler;
    localparam int RD = 10, RR = 4, D = 4;
    logic       clock = 0, reset = 0, clear_dropped = 0, cmd_ready = 0;
    logic [9:0] keys = '0;
    logic       dropped;
    logic [2:0] fifo_level;
    int total = 0, bad = 0;
    key_cmd_if bus();
    assign bus.cmd_ready = cmd_ready;
    key_cmd_scheduler #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIFO_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .keys(keys), .clear_dropped(clear_dropped),
        .cmd(bus.master), .dropped(dropped), .fifo_level(fifo_level));
    always #5 clock = ~clock;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // reference model: repeat timing expressed as absolute due times
    logic [4:0] mq[$];
    logic [4:0] acc[$];
    logic [9:0] mpend, mkq, m_rise;
    logic       mrep, mact, mdrop, m_dr, m_can, m_pop, m_used;
    logic [3:0] mtrk;
    int         t, due, m_sel;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mpend = '0; mkq = '1; mrep = 0; mact = 0; mdrop = 0; mtrk = 0; t = 0; due = 0;
        end else begin
            m_pop = mq.size() > 0 && cmd_ready;
            m_can = mq.size() < D || m_pop;
            m_rise = keys & ~mkq;
            m_dr = |(m_rise & mpend);
            m_sel = -1;
            for (int i = 9; i >= 0; i--) if (mpend[i]) m_sel = i;
            m_used = 0;
            if (m_pop) void'(mq.pop_front());
            if (m_can && m_sel >= 0) begin
                mq.push_back({1'b0, 4'(m_sel)});
                mpend[m_sel] = 1'b0;
            end else if (m_can && mrep) begin
                mq.push_back({1'b1, mtrk});
                m_used = 1;
            end
            mpend = mpend | m_rise;
            if (m_can && m_sel >= 0 && m_sel < 8) begin
                mtrk = 4'(m_sel); mact = 1; due = t + RD; mrep = 0;
            end else if (mact && !keys[mtrk]) begin
                mact = 0; mrep = 0;
            end else if (mact && t == due) begin
                if (mrep && !m_used) m_dr = 1;
                mrep = 1; due = t + RR;
            end else if (m_used) begin
                mrep = 0;
            end
            mdrop = m_dr ? 1'b1 : (clear_dropped ? 1'b0 : mdrop);
            mkq = keys;
            t++;
        end
    end

    always @(negedge clock) begin
        check("valid", bus.cmd_valid, mq.size() > 0);
        check("code", bus.cmd_code, mq.size() > 0 ? int'(mq[0][3:0]) : 0);
        check("repeat", bus.cmd_repeat, mq.size() > 0 ? int'(mq[0][4]) : 0);
        check("level", fifo_level, mq.size());
        check("dropped", dropped, mdrop);
        if (bus.cmd_valid && cmd_ready) acc.push_back({bus.cmd_repeat, bus.cmd_code});
    end

    initial begin
        int nrep, exp_full[6];
        exp_full = '{1, 2, 3, 8, 0, 9};
        cyc(2);
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_dropped", dropped, 0);
        #3 reset = 1;
        cyc(2);
        // single press of w
        cmd_ready = 1; keys = 10'h001;
        cyc(1); check("sp_early", bus.cmd_valid, 0);
        cyc(1); check("sp_valid", bus.cmd_valid, 1); check("sp_code", bus.cmd_code, 0);
        check("sp_rep", bus.cmd_repeat, 0);
        keys = '0;
        cyc(1); check("sp_once", bus.cmd_valid, 0);
        cyc(3);
        // simultaneous a, space, enter
        cmd_ready = 0; keys = 10'h302;
        cyc(1); keys = '0;
        cyc(3);
        check("sim_level", fifo_level, 3); check("sim_c0", bus.cmd_code, 1);
        check("sim_drop", dropped, 0);
        cmd_ready = 1;
        cyc(1); check("sim_c1", bus.cmd_code, 8); check("sim_l1", fifo_level, 2);
        cyc(1); check("sim_c2", bus.cmd_code, 9);
        cyc(1); check("sim_empty", bus.cmd_valid, 0);
        cyc(3);
        // auto-repeat on up
        acc.delete(); keys = 10'h040;
        cyc(30); keys = '0; cyc(5);
        nrep = 0;
        foreach (acc[i]) begin
            check("ar_code", acc[i][3:0], 6);
            nrep += int'(acc[i][4]);
        end
        check("ar_count", acc.size(), 6);
        check("ar_reps", nrep, 5);
        // space never repeats
        acc.delete(); keys = 10'h100;
        cyc(30); keys = '0; cyc(5);
        check("sp_count", acc.size(), 1);
        check("sp_entry", acc.size() > 0 ? int'(acc[0]) : -1, 8);
        // full FIFO with coalesced press
        acc.delete(); cmd_ready = 0; keys = 10'h10E;
        cyc(1); keys = '0; cyc(4);
        keys = 10'h200; cyc(1); keys = '0; cyc(1);
        keys = 10'h001; cyc(1); keys = '0; cyc(1);
        keys = 10'h001; cyc(1); keys = '0;
        check("full_level", fifo_level, 4); check("full_drop", dropped, 1);
        check("full_head", bus.cmd_code, 1);
        cmd_ready = 1;
        cyc(1); check("full_pop_push", fifo_level, 4);
        cyc(5); check("full_drained", fifo_level, 0);
        check("full_count", acc.size(), 6);
        for (int i = 0; i < 6; i++) check("full_order", acc.size() > i ? int'(acc[i]) : -1, exp_full[i]);
        clear_dropped = 1; cyc(1); clear_dropped = 0;
        check("clr_drop", dropped, 0);
        cyc(2);
        // reset in the middle of repeating
        cmd_ready = 0; keys = 10'h040;
        cyc(18);
        check("mid_level", fifo_level, 3); check("mid_code", bus.cmd_code, 6);
        #2 reset = 0;
        #1;
        check("ar_valid", bus.cmd_valid, 0); check("ar_level", fifo_level, 0);
        check("ar_code0", bus.cmd_code, 0); check("ar_rep0", bus.cmd_repeat, 0);
        check("ar_drop0", dropped, 0);
        cyc(2); #3 reset = 1;
        cyc(15); check("held_quiet", bus.cmd_valid, 0); check("held_level", fifo_level, 0);
        keys = '0; cyc(2);
        keys = 10'h040; cyc(2);
        check("repress_valid", bus.cmd_valid, 1); check("repress_code", bus.cmd_code, 6);
        check("repress_rep", bus.cmd_repeat, 0);
        keys = '0; cmd_ready = 1; cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
